key_event_arbiter: RTL

Debounces NUM_KEYS active-low push-buttons, converts each debounced press (falling edge) into a sticky pending request, and serialises pending requests into one key-index event stream with a valid/ready handshake. It sits between raw board buttons and any consumer of button events (mode FSMs, UART command logic), and replaces per-key single-pulse detectors wherever several keys share one consumer. Fairness is round-robin. Presses lost while a key is still pending are flagged per key.

---
 rtl/key_pkg.sv | 12 +
 rtl/key_debounce.sv | 48 ++++
 rtl/key_event_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared types and default parameters for the key event arbiter.
package key_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_OFFER
  } arb_state_e;

  localparam int unsigned DEF_NUM_KEYS        = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/key_debounce.sv
// Per-key synchroniser and debouncer; emits a one-cycle press strobe in the
// cycle before the stable level falls, so pending can be set on that same edge.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int unsigned       CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_flip;

  assign w_diff  = (r_sync2 != r_stable);
  assign w_flip  = w_diff && (r_cnt == CNT_MAX);
  assign o_press = w_flip && r_stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_event_arbiter.sv
// Debounced multi-key press detector with sticky pending requests, per-key
// overrun flags and a round-robin valid/ready event stream.
module key_event_arbiter
  import key_pkg::*;
#(
  parameter  int unsigned NUM_KEYS        = DEF_NUM_KEYS,
  parameter  int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  localparam int unsigned IDX_W           = $clog2(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic                evt_valid,
  output logic [IDX_W-1:0]    evt_idx,
  input  logic                evt_ready,
  output logic [NUM_KEYS-1:0] overrun,
  input  logic                clr_overrun
);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [IDX_W-1:0]    r_last;
  logic [IDX_W-1:0]    w_last_nxt;
  logic [IDX_W-1:0]    w_pick;
  logic [IDX_W:0]      w_sum;
  logic                w_any;
  logic                w_hs;
  logic [NUM_KEYS-1:0] w_hs_vec;
  logic [NUM_KEYS-1:0] w_press;
  logic [NUM_KEYS-1:0] w_ovr_set;
  logic [NUM_KEYS-1:0] r_pending;
  logic [NUM_KEYS-1:0] r_overrun;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_key_n(key_n[k]),
      .o_press(w_press[k])
    );
  end

  // A press landing on the key being handshaked re-arms it instead of overrunning.
  assign w_hs_vec  = NUM_KEYS'(w_hs) << r_idx;
  assign w_ovr_set = w_press & r_pending & ~w_hs_vec;
  assign overrun   = r_overrun;
  assign evt_idx   = r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      r_pending <= (r_pending & ~w_hs_vec) | w_press;
      r_overrun <= (clr_overrun ? '0 : r_overrun) | w_ovr_set;
    end
  end

  // Round-robin scan starting just after the last granted key, modulo NUM_KEYS.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_sum  = '0;
    for (int unsigned i = 1; i <= NUM_KEYS; i++) begin
      w_sum = {1'b0, r_last} + (IDX_W+1)'(i);
      if (w_sum >= (IDX_W+1)'(NUM_KEYS)) begin
        w_sum = w_sum - (IDX_W+1)'(NUM_KEYS);
      end
      if (!w_any && r_pending[w_sum[IDX_W-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_sum[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_last  <= IDX_W'(NUM_KEYS - 1);
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
    w_hs        = 1'b0;
    evt_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_idx_nxt   = w_pick;
          w_state_nxt = ST_OFFER;
        end
      end
      ST_OFFER: begin
        evt_valid = 1'b1;
        if (evt_ready) begin
          w_hs        = 1'b1;
          w_last_nxt  = r_idx;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
